// File: rtl/cu_stream_cmd_generator_pkg.sv
// ---------------------------------------------------------------------------
// cu_stream_cmd_generator_pkg
// Shared types and helpers for the compute-unit stream command generators.
//   stream_state      : state encoding for both read and write stream engines
//   CMD_SIZE_BITS     : width of the command byte-size field
//   cmd_size_aligned  : picks the largest power-of-two command that fits the
//                       remaining bytes, the size cap and the address alignment
// ---------------------------------------------------------------------------
package cu_stream_cmd_generator_pkg;

   localparam int CMD_SIZE_BITS = 12;

   typedef enum logic [2:0] {
      STREAM_RESET   = 3'd0,
      STREAM_IDLE    = 3'd1,
      STREAM_SET     = 3'd2,
      STREAM_REQ     = 3'd3,
      STREAM_PENDING = 3'd4,
      STREAM_DONE    = 3'd5,
      STREAM_FINAL   = 3'd6
   } stream_state;

   // Round-down size selection. max_bytes must be a power of two, so the
   // alignment limit (lowest set address bit, or max_bytes for address 0)
   // is also a power of two; only the remaining-bytes term needs rounding.
   // Expects remaining != 0.
   function automatic logic [63:0] cmd_size_aligned(input logic [63:0] addr,
                                                    input logic [63:0] remaining,
                                                    input logic [63:0] max_bytes);
      logic [63:0] lim;
      logic [63:0] low_bit;
      logic [63:0] res;
      lim     = max_bytes;
      low_bit = addr & (~addr + 64'd1);
      if ((addr != 64'd0) && (low_bit < lim)) begin
         lim = low_bit;
      end
      if (remaining >= lim) begin
         res = lim;
      end else begin
         res = 64'd0;
         for (int i = 0; i < 64; i++) begin
            if (remaining[i]) begin
               res = 64'd1 << i;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/cu_stream_cmd_generator_credit_counter.sv
// ---------------------------------------------------------------------------
// cu_credit_counter
// Tracks commands issued but not yet responded to.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   inc          : one command issued this cycle
//   dec          : one response received this cycle
//   has_credit   : outstanding < CREDIT_MAX
//   zero         : outstanding == 0
//   underflow    : a response arrived with nothing outstanding (pulse)
// ---------------------------------------------------------------------------
module cu_credit_counter #(
   parameter int CREDIT_MAX = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic inc,
   input  logic dec,
   output logic has_credit,
   output logic zero,
   output logic underflow
);

   localparam int CNT_BITS = $clog2(CREDIT_MAX + 1);

   logic [CNT_BITS-1:0] count;
   logic                dec_eff;

   assign zero       = (count == '0);
   assign has_credit = (count < CNT_BITS'(CREDIT_MAX));
   assign underflow  = dec && zero;
   // A response with nothing outstanding is dropped so the count never wraps.
   assign dec_eff    = dec && !zero;

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else begin
         case ({inc, dec_eff})
            2'b10:   count <= count + CNT_BITS'(1);
            2'b01:   count <= count - CNT_BITS'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cu_stream_cmd_generator.sv
// ---------------------------------------------------------------------------
// cu_stream_cmd_generator
// Splits a stream of num_elements elements at base_addr into power-of-two,
// self-aligned commands no larger than MAX_CMD_BYTES, issues them under a
// credit limit with rolling tags and pulses done when all have completed.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   start                 : one-cycle request, accepted only in IDLE
//   base_addr             : stream start (low element-offset bits ignored)
//   num_elements          : element count
//   cmd_valid / cmd_ready : command handshake toward the arbiter
//   cmd_addr/size/tag     : registered command fields
//   cmd_write             : WRITE_MODE
//   rsp_valid             : one command completed
//   busy, done            : activity flag and one-cycle completion pulse
//   rsp_error             : sticky, response seen with nothing outstanding
//   fsm_state             : current stream_state encoding (debug)
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. While cmd_valid is 1 without cmd_ready the fields
// hold; cmd_valid only rises when a credit is free, so it never drops
// before its handshake.
// ---------------------------------------------------------------------------
module cu_stream_cmd_generator
   import cu_stream_cmd_generator_pkg::*;
#(
   parameter int ELEM_BYTES    = 8,
   parameter int MAX_CMD_BYTES = 128,
   parameter int ADDR_BITS     = 64,
   parameter int COUNT_BITS    = 32,
   parameter int TAG_BITS      = 8,
   parameter int CREDIT_MAX    = 16,
   parameter int WRITE_MODE    = 0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [ADDR_BITS-1:0]     base_addr,
   input  logic [COUNT_BITS-1:0]    num_elements,
   output logic                     cmd_valid,
   input  logic                     cmd_ready,
   output logic [ADDR_BITS-1:0]     cmd_addr,
   output logic [CMD_SIZE_BITS-1:0] cmd_size,
   output logic [TAG_BITS-1:0]      cmd_tag,
   output logic                     cmd_write,
   input  logic                     rsp_valid,
   output logic                     busy,
   output logic                     done,
   output logic                     rsp_error,
   output logic [2:0]               fsm_state
);

   localparam int                   ELEM_SHIFT = $clog2(ELEM_BYTES);
   localparam int                   REM_BITS   = COUNT_BITS + ELEM_SHIFT;
   localparam logic [ADDR_BITS-1:0] ELEM_MASK  = ADDR_BITS'(ELEM_BYTES - 1);

   stream_state              state;
   stream_state              next_state;
   logic [REM_BITS-1:0]      rem_q;
   logic [REM_BITS-1:0]      next_rem;
   logic [REM_BITS-1:0]      calc_rem;
   logic [ADDR_BITS-1:0]     next_addr;
   logic [ADDR_BITS-1:0]     calc_addr;
   logic [CMD_SIZE_BITS-1:0] calc_size;
   logic                     handshake;
   logic                     has_credit;
   logic                     credit_zero;
   logic                     underflow;

   assign cmd_write = (WRITE_MODE != 0);
   assign fsm_state = state;
   assign handshake = cmd_valid && cmd_ready;

   // Address and remaining count after the command currently presented.
   assign next_addr = cmd_addr + ADDR_BITS'(cmd_size);
   assign next_rem  = rem_q - REM_BITS'(cmd_size);

   // One size calculator: SET sizes the first command from the latched
   // start, REQ sizes the following command during the handshake cycle.
   assign calc_addr = (state == STREAM_SET) ? cmd_addr : next_addr;
   assign calc_rem  = (state == STREAM_SET) ? rem_q : next_rem;
   assign calc_size = CMD_SIZE_BITS'(cmd_size_aligned(64'(calc_addr), 64'(calc_rem),
                                                      64'(MAX_CMD_BYTES)));

   cu_credit_counter #(
      .CREDIT_MAX(CREDIT_MAX)
   ) u_credit (
      .clock     (clock),
      .reset     (reset),
      .inc       (handshake),
      .dec       (rsp_valid),
      .has_credit(has_credit),
      .zero      (credit_zero),
      .underflow (underflow)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= STREAM_RESET;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      cmd_valid  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         STREAM_RESET: begin
            next_state = STREAM_IDLE;
         end
         STREAM_IDLE: begin
            // busy rises in the accepting cycle so the controller never sees
            // an idle gap between its start pulse and the stream running.
            busy = start;
            if (start) begin
               next_state = STREAM_SET;
            end
         end
         STREAM_SET: begin
            busy       = 1'b1;
            next_state = (rem_q == '0) ? STREAM_DONE : STREAM_REQ;
         end
         STREAM_REQ: begin
            busy      = 1'b1;
            cmd_valid = has_credit;
            if (cmd_valid && cmd_ready && (next_rem == '0)) begin
               next_state = STREAM_PENDING;
            end
         end
         STREAM_PENDING: begin
            busy = 1'b1;
            if (credit_zero) begin
               next_state = STREAM_DONE;
            end
         end
         STREAM_DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            next_state = STREAM_FINAL;
         end
         STREAM_FINAL: begin
            busy       = 1'b1;
            next_state = STREAM_IDLE;
         end
         default: begin
            next_state = STREAM_RESET;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cmd_addr  <= '0;
         cmd_size  <= '0;
         cmd_tag   <= '0;
         rem_q     <= '0;
         rsp_error <= 1'b0;
      end else begin
         if (underflow) begin
            rsp_error <= 1'b1;
         end
         case (state)
            STREAM_IDLE: begin
               if (start) begin
                  cmd_addr <= base_addr & ~ELEM_MASK;
                  rem_q    <= REM_BITS'(num_elements) << ELEM_SHIFT;
               end
            end
            STREAM_SET: begin
               if (rem_q != '0) begin
                  cmd_size <= calc_size;
               end
            end
            STREAM_REQ: begin
               if (handshake) begin
                  // Tags roll on across streams; fields keep the last
                  // command once the stream is exhausted.
                  cmd_tag <= cmd_tag + TAG_BITS'(1);
                  rem_q   <= next_rem;
                  if (next_rem != '0) begin
                     cmd_addr <= next_addr;
                     cmd_size <= calc_size;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cu_stream_cmd_generator.sv
module tb_cu_stream_cmd_generator;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   // ---------------- DUT a: 128 B commands, 2-bit tags, read ----------------
   logic        start_a = 1'b0;
   logic [63:0] base_addr_a = '0;
   logic [31:0] num_elements_a = '0;
   logic        cmd_valid_a;
   logic        cmd_ready_a = 1'b0;
   logic [63:0] cmd_addr_a;
   logic [11:0] cmd_size_a;
   logic [1:0]  cmd_tag_a;
   logic        cmd_write_a;
   logic        rsp_valid_a = 1'b0;
   logic        busy_a, done_a, rsp_error_a;
   logic [2:0]  fsm_state_a;

   // ---------------- DUT b: 16 B commands, 2 credits, write ----------------
   logic        start_b = 1'b0;
   logic [63:0] base_addr_b = '0;
   logic [31:0] num_elements_b = '0;
   logic        cmd_valid_b;
   logic        cmd_ready_b = 1'b0;
   logic [63:0] cmd_addr_b;
   logic [11:0] cmd_size_b;
   logic [7:0]  cmd_tag_b;
   logic        cmd_write_b;
   logic        rsp_valid_b = 1'b0;
   logic        busy_b, done_b, rsp_error_b;
   logic [2:0]  fsm_state_b;

   cu_stream_cmd_generator #(
      .ELEM_BYTES(8), .MAX_CMD_BYTES(128), .ADDR_BITS(64), .COUNT_BITS(32),
      .TAG_BITS(2), .CREDIT_MAX(16), .WRITE_MODE(0)
   ) dut_a (
      .clock(clock), .reset(reset), .start(start_a), .base_addr(base_addr_a),
      .num_elements(num_elements_a), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
      .cmd_addr(cmd_addr_a), .cmd_size(cmd_size_a), .cmd_tag(cmd_tag_a),
      .cmd_write(cmd_write_a), .rsp_valid(rsp_valid_a), .busy(busy_a), .done(done_a),
      .rsp_error(rsp_error_a), .fsm_state(fsm_state_a)
   );

   cu_stream_cmd_generator #(
      .ELEM_BYTES(8), .MAX_CMD_BYTES(16), .ADDR_BITS(64), .COUNT_BITS(32),
      .TAG_BITS(8), .CREDIT_MAX(2), .WRITE_MODE(1)
   ) dut_b (
      .clock(clock), .reset(reset), .start(start_b), .base_addr(base_addr_b),
      .num_elements(num_elements_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
      .cmd_addr(cmd_addr_b), .cmd_size(cmd_size_b), .cmd_tag(cmd_tag_b),
      .cmd_write(cmd_write_b), .rsp_valid(rsp_valid_b), .busy(busy_b), .done(done_b),
      .rsp_error(rsp_error_b), .fsm_state(fsm_state_b)
   );

   localparam logic [2:0] ST_RESET   = 3'd0;
   localparam logic [2:0] ST_IDLE    = 3'd1;
   localparam logic [2:0] ST_SET     = 3'd2;
   localparam logic [2:0] ST_PENDING = 3'd4;

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [83:0] exp_a_q[$];
   logic [83:0] exp_b_q[$];
   int exp_tag_a = 0;
   int exp_tag_b = 0;

   task automatic check(input string name, input logic [83:0] act, input logic [83:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_a(input logic [63:0] addr, input logic [11:0] size);
      exp_a_q.push_back({addr, size, 8'(exp_tag_a % 4)});
      exp_tag_a++;
   endtask

   task automatic push_b(input logic [63:0] addr, input logic [11:0] size);
      exp_b_q.push_back({addr, size, 8'(exp_tag_b % 256)});
      exp_tag_b++;
   endtask

   // ---------------- monitors ----------------
   logic        pv_a = 1'b0, pr_a = 1'b0;
   logic [83:0] pf_a = '0;
   logic        pv_b = 1'b0, pr_b = 1'b0;
   logic [83:0] pf_b = '0;

   always @(negedge clock) begin
      logic [83:0] cur;
      cur = {cmd_addr_a, cmd_size_a, 8'(cmd_tag_a)};
      if (reset) begin
         pv_a = 1'b0;
         pr_a = 1'b0;
      end else begin
         if (pv_a && !pr_a && cmd_valid_a) check("a_stall_hold", cur, pf_a);
         if (cmd_valid_a && cmd_ready_a) begin
            check("a_cmd_write", 84'(cmd_write_a), 84'(0));
            if (exp_a_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL a_unexpected_cmd actual=%0h required=none", cur);
            end else begin
               check("a_cmd", cur, exp_a_q.pop_front());
            end
         end
         pv_a = cmd_valid_a;
         pr_a = cmd_ready_a;
         pf_a = cur;
      end
   end

   always @(negedge clock) begin
      logic [83:0] cur;
      cur = {cmd_addr_b, cmd_size_b, cmd_tag_b};
      if (reset) begin
         pv_b = 1'b0;
         pr_b = 1'b0;
      end else begin
         if (pv_b && !pr_b && cmd_valid_b) check("b_stall_hold", cur, pf_b);
         if (cmd_valid_b && cmd_ready_b) begin
            check("b_cmd_write", 84'(cmd_write_b), 84'(1));
            if (exp_b_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL b_unexpected_cmd actual=%0h required=none", cur);
            end else begin
               check("b_cmd", cur, exp_b_q.pop_front());
            end
         end
         pv_b = cmd_valid_b;
         pr_b = cmd_ready_b;
         pf_b = cur;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Returns one cycle after the start pulse (the SET cycle).
   task automatic go_a(input logic [63:0] base, input logic [31:0] num);
      base_addr_a    = base;
      num_elements_a = num;
      start_a        = 1'b1;
      #1;
      check("a_busy_on_start", 84'(busy_a), 84'(1));
      tick();
      start_a = 1'b0;
   endtask

   task automatic go_b(input logic [63:0] base, input logic [31:0] num);
      base_addr_b    = base;
      num_elements_b = num;
      start_b        = 1'b1;
      #1;
      check("b_busy_on_start", 84'(busy_b), 84'(1));
      tick();
      start_b = 1'b0;
   endtask

   task automatic rsp_a(input int n);
      for (int i = 0; i < n; i++) begin
         rsp_valid_a = 1'b1;
         tick();
      end
      rsp_valid_a = 1'b0;
   endtask

   task automatic rsp_b(input int n);
      for (int i = 0; i < n; i++) begin
         rsp_valid_b = 1'b1;
         tick();
      end
      rsp_valid_b = 1'b0;
   endtask

   task automatic wait_issued_a(input int max_cycles);
      int n = 0;
      while (exp_a_q.size() != 0 && n < max_cycles) begin
         tick();
         n++;
      end
      check("a_issue_timeout", 84'(exp_a_q.size()), 84'(0));
   endtask

   // Called in the cycle after the last response: done follows one cycle
   // later for exactly one cycle, then FINAL, then IDLE.
   task automatic check_done(input bit sel);
      check(sel ? "b_done_early" : "a_done_early", 84'(sel ? done_b : done_a), 84'(0));
      tick();
      check(sel ? "b_done_pulse" : "a_done_pulse", 84'(sel ? done_b : done_a), 84'(1));
      tick();
      check(sel ? "b_done_single" : "a_done_single", 84'(sel ? done_b : done_a), 84'(0));
      check(sel ? "b_busy_final" : "a_busy_final", 84'(sel ? busy_b : busy_a), 84'(1));
      tick();
      check(sel ? "b_idle_after" : "a_idle_after", 84'(sel ? busy_b : busy_a), 84'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      tick();
      tick();
      check("a_rst_valid", 84'(cmd_valid_a), 84'(0));
      check("a_rst_fields", {cmd_addr_a, cmd_size_a, 8'(cmd_tag_a)}, 84'(0));
      check("a_rst_busy_done_err", 84'({busy_a, done_a, rsp_error_a}), 84'(0));
      check("a_rst_state", 84'(fsm_state_a), 84'(ST_RESET));
      check("a_rst_write", 84'(cmd_write_a), 84'(0));
      check("b_rst_write", 84'(cmd_write_b), 84'(1));
      check("b_rst_valid", 84'(cmd_valid_b), 84'(0));
      reset = 1'b0;
      tick();
      check("a_state_idle", 84'(fsm_state_a), 84'(ST_IDLE));

      // 6 x 128 B from 0, 2-bit tags 0,1,2,3,0,1; first command stalled 5 cycles
      for (int i = 0; i < 6; i++) push_a(64'(i * 128), 12'd128);
      cmd_ready_a = 1'b0;
      go_a(64'h0, 32'd96);
      check("a_set_state", 84'(fsm_state_a), 84'(ST_SET));
      check("a_valid_t1", 84'(cmd_valid_a), 84'(0));
      tick();
      check("a_valid_t2", 84'(cmd_valid_a), 84'(1));
      repeat (5) tick();
      check("a_stall_valid", 84'(cmd_valid_a), 84'(1));
      check("a_stall_fields", {cmd_addr_a, cmd_size_a, 8'(cmd_tag_a)}, {64'h0, 12'd128, 8'd0});
      cmd_ready_a = 1'b1;
      wait_issued_a(50);
      check("a_pending", 84'(fsm_state_a), 84'(ST_PENDING));
      rsp_a(6);
      check_done(1'b0);

      // 40 elements at 0x1000: 128, 128, 64; start during PENDING is ignored
      push_a(64'h1000, 12'd128);
      push_a(64'h1080, 12'd128);
      push_a(64'h1100, 12'd64);
      go_a(64'h1000, 32'd40);
      wait_issued_a(50);
      base_addr_a    = 64'h5000;
      num_elements_a = 32'd4;
      start_a        = 1'b1;
      tick();
      start_a = 1'b0;
      rsp_a(2);
      repeat (3) tick();
      check("a_no_done_two_rsp", 84'(done_a), 84'(0));
      check("a_pending_two_rsp", 84'(fsm_state_a), 84'(ST_PENDING));
      rsp_a(1);
      check_done(1'b0);

      // 5 elements at 0x1008: 8, 16, 16 ending at 0x102F
      push_a(64'h1008, 12'd8);
      push_a(64'h1010, 12'd16);
      push_a(64'h1020, 12'd16);
      go_a(64'h1008, 32'd5);
      wait_issued_a(50);
      rsp_a(3);
      check_done(1'b0);

      // unaligned base is truncated to the element boundary
      push_a(64'h2000, 12'd16);
      go_a(64'h2003, 32'd2);
      wait_issued_a(50);
      rsp_a(1);
      check_done(1'b0);

      // zero elements: no command, done at t+2, busy t..t+3
      go_a(64'h4000, 32'd0);
      check("a_zero_busy_t1", 84'(busy_a), 84'(1));
      check("a_zero_valid_t1", 84'(cmd_valid_a), 84'(0));
      tick();
      check("a_zero_done_t2", 84'(done_a), 84'(1));
      check("a_zero_busy_t2", 84'(busy_a), 84'(1));
      check("a_zero_valid_t2", 84'(cmd_valid_a), 84'(0));
      tick();
      check("a_zero_done_t3", 84'(done_a), 84'(0));
      check("a_zero_busy_t3", 84'(busy_a), 84'(1));
      tick();
      check("a_zero_busy_t4", 84'(busy_a), 84'(0));
      check("a_zero_idle_t4", 84'(fsm_state_a), 84'(ST_IDLE));

      // credit limit 2: 4 x 16 B from 0, responses withheld
      for (int i = 0; i < 4; i++) push_b(64'(i * 16), 12'd16);
      cmd_ready_b = 1'b1;
      go_b(64'h0, 32'd8);
      tick();
      check("b_valid_first", 84'(cmd_valid_b), 84'(1));
      tick();
      check("b_valid_second", 84'(cmd_valid_b), 84'(1));
      tick();
      check("b_no_credit", 84'(cmd_valid_b), 84'(0));
      tick();
      check("b_credit_held", 84'(cmd_valid_b), 84'(0));
      rsp_valid_b = 1'b1;
      tick();
      check("b_valid_after_rsp", 84'(cmd_valid_b), 84'(1));
      tick();
      rsp_valid_b = 1'b0;
      check("b_same_cycle_hold", 84'(cmd_valid_b), 84'(1));
      tick();
      check("b_valid_full", 84'(cmd_valid_b), 84'(0));
      check("b_pending", 84'(fsm_state_b), 84'(ST_PENDING));
      check("b_all_issued", 84'(exp_b_q.size()), 84'(0));
      rsp_b(1);
      repeat (3) tick();
      check("b_no_done_one_left", 84'(done_b), 84'(0));
      check("b_pending_one_left", 84'(fsm_state_b), 84'(ST_PENDING));
      rsp_b(1);
      check_done(1'b1);

      // reset after 2 of 4 commands, late responses, then a clean stream
      push_a(64'h0, 12'd128);
      push_a(64'h80, 12'd128);
      cmd_ready_a = 1'b0;
      go_a(64'h0, 32'd64);
      tick();
      cmd_ready_a = 1'b1;
      tick();
      tick();
      cmd_ready_a = 1'b0;
      reset       = 1'b1;
      exp_tag_a   = 0;
      exp_tag_b   = 0;
      tick();
      check("a_mid_rst_valid", 84'(cmd_valid_a), 84'(0));
      check("a_mid_rst_fields", {cmd_addr_a, cmd_size_a, 8'(cmd_tag_a)}, 84'(0));
      check("a_mid_rst_busy", 84'(busy_a), 84'(0));
      check("a_mid_rst_state", 84'(fsm_state_a), 84'(ST_RESET));
      check("a_mid_rst_queue", 84'(exp_a_q.size()), 84'(0));
      reset = 1'b0;
      tick();
      check("a_err_clear", 84'(rsp_error_a), 84'(0));
      rsp_a(1);
      check("a_err_first_late", 84'(rsp_error_a), 84'(1));
      rsp_a(1);
      check("a_err_second_late", 84'(rsp_error_a), 84'(1));
      push_a(64'h3000, 12'd16);
      cmd_ready_a = 1'b1;
      go_a(64'h3000, 32'd2);
      wait_issued_a(50);
      rsp_a(1);
      check_done(1'b0);
      check("a_err_sticky", 84'(rsp_error_a), 84'(1));
      check("b_err_none", 84'(rsp_error_b), 84'(0));

      repeat (3) tick();
      check("a_queue_empty", 84'(exp_a_q.size()), 84'(0));
      check("b_queue_empty", 84'(exp_b_q.size()), 84'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
